// File: rtl/pim_input_buffer.sv
// Host-to-PIM staging buffer: packs 32-bit host words into 1024-bit rows
// across two ping-pong banks and hands complete rows out via valid/ready.
module pim_input_buffer #(
  parameter int WORD_W    = 32,
  parameter int ROW_W     = 1024,
  parameter int ROW_BYTES = 128
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic              data_valid_i,
  output logic              data_ready_o,
  output logic [ROW_W-1:0]  row_o,
  output logic              row_valid_o,
  input  logic              row_ready_i,
  output logic [6:0]        words_o
);

  localparam int WPR = ROW_BYTES / 4;

  // Each bank holds its words already byte-swapped so that byte 0 of the
  // bank lands in the most significant byte of the row.
  logic [WORD_W-1:0] r_mem [2][WPR];
  logic [5:0]        r_wr_ptr;
  logic              r_rd_bank;
  logic [1:0]        r_full;
  logic [6:0]        r_words;

  logic              w_wr;
  logic              w_rd;
  logic [ROW_W-1:0]  w_row;

  function automatic logic [WORD_W-1:0] f_bswap(input logic [WORD_W-1:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  assign data_ready_o = ~r_full[r_wr_ptr[5]];
  assign row_valid_o  = r_full[r_rd_bank];
  assign words_o      = r_words;

  // clear_i wins over both handshakes
  assign w_wr = data_valid_i & data_ready_o & ~clear_i;
  assign w_rd = row_valid_o & row_ready_i & ~clear_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr  <= '0;
      r_rd_bank <= 1'b0;
      r_full    <= 2'b00;
      r_words   <= '0;
    end else if (clear_i) begin
      r_wr_ptr  <= '0;
      r_rd_bank <= 1'b0;
      r_full    <= 2'b00;
      r_words   <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 6'd1;
        if (r_wr_ptr[4:0] == 5'd31) r_full[r_wr_ptr[5]] <= 1'b1;
      end
      // A bank being filled is never the bank being popped, so the two
      // flag updates always touch different bits.
      if (w_rd) begin
        r_full[r_rd_bank] <= 1'b0;
        r_rd_bank         <= ~r_rd_bank;
      end
      r_words <= r_words + {6'd0, w_wr} - (w_rd ? 7'd32 : 7'd0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < 2; b++) begin
        for (int w = 0; w < WPR; w++) begin
          r_mem[b][w] <= '0;
        end
      end
    end else if (w_wr) begin
      r_mem[r_wr_ptr[5]][r_wr_ptr[4:0]] <= f_bswap(data_i);
    end
  end

  always_comb begin
    w_row = '0;
    if (row_valid_o) begin
      for (int w = 0; w < WPR; w++) begin
        w_row[ROW_W-1-WORD_W*w -: WORD_W] = r_mem[r_rd_bank][w];
      end
    end
  end

  assign row_o = w_row;

endmodule
